// File: rtl/wb_stage_pkg.sv
// Shared definitions for the Minisys-1A MEM->WB writeback stage.
//  - writeback source select codes (in_wb_sel)
//  - memory access size codes (in_mem_size)
//  - FSM state type
//  - alignment rule shared by the stage and its load extractor
package wb_stage_pkg;

   localparam logic [2:0] WB_SEL_ALU  = 3'd0;
   localparam logic [2:0] WB_SEL_MEM  = 3'd1;
   localparam logic [2:0] WB_SEL_CP0  = 3'd2;
   localparam logic [2:0] WB_SEL_HI   = 3'd3;
   localparam logic [2:0] WB_SEL_LO   = 3'd4;
   localparam logic [2:0] WB_SEL_LINK = 3'd5;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_WAIT_LD = 1'b1
   } wb_state_e;

   // Halves need an even address; words (size 2, and 3 which aliases word)
   // need a 4-byte aligned address. Bytes are always aligned.
   function automatic logic load_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_low);
      logic mis;
      case (size)
         MEM_SIZE_BYTE: mis = 1'b0;
         MEM_SIZE_HALF: mis = addr_low[0];
         default:       mis = |addr_low;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational sub-word load extractor.
// Picks the addressed byte/half lane out of a little-endian read word and
// zero- or sign-extends it to DATA_W; words pass through unchanged.
// Ports:
//   rdata_i      read data from DATA RAM / IO
//   size_i       0 byte, 1 half, 2/3 word
//   signed_i     sign-extend sub-word result
//   addr_low_i   address bits [1:0] (byte lane; bit 1 selects half lane)
//   ext_o        aligned, extended result
//   misaligned_o access violates natural alignment
module wb_stage_load_ext
   import wb_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   input  logic [1:0]        addr_low_i,
   output logic [DATA_W-1:0] ext_o,
   output logic              misaligned_o
);

   logic [31:0] w32;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Sub-word lanes always live in the low 32 bits of the read word.
   assign w32    = rdata_i[31:0];
   assign byte_v = w32[{addr_low_i, 3'b000} +: 8];
   assign half_v = w32[{addr_low_i[1], 4'b0000} +: 16];

   always_comb begin
      ext_o = rdata_i;
      case (size_i)
         MEM_SIZE_BYTE: ext_o = {{(DATA_W-8){signed_i & byte_v[7]}}, byte_v};
         MEM_SIZE_HALF: ext_o = {{(DATA_W-16){signed_i & half_v[15]}}, half_v};
         default:       ext_o = rdata_i;
      endcase
   end

   assign misaligned_o = load_misaligned(size_i, addr_low_i);

endmodule

// File: rtl/wb_stage.sv
// Registered MEM->WB writeback stage for the Minisys-1A pipeline.
// Selects the ALU/MEM/CP0/HI/LO/LINK result, waits for slow DATA RAM/IO
// reads, and drives the register-file write port plus a one-cycle-delayed
// forwarding copy for read-after-write hazard resolution.
// Ports:
//   clock, reset (sync, active-high), flush (sync pipeline flush)
//   in_valid / in_ready          upstream handshake (ready = state IDLE)
//   in_wb_sel, in_reg_write, in_rd, in_mem_size, in_mem_signed,
//   in_addr_low, in_alu_result, in_cp0_data, in_hi, in_lo, in_link_pc
//                                op control and source operands
//   mem_rdata, mem_rdata_valid   load return (valid only sampled in WAIT_LD)
//   wb_en / wb_addr / wb_data    register-file write port (registered)
//   fwd_valid / fwd_addr / fwd_data   wb_* delayed one cycle
//   misalign_err                 pulse: misaligned load dropped
//   load_timeout                 pulse: load abandoned after WAIT_MAX cycles
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_wb_sel,
   input  logic               in_reg_write,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic [1:0]         in_mem_size,
   input  logic               in_mem_signed,
   input  logic [1:0]         in_addr_low,
   input  logic [DATA_W-1:0]  in_alu_result,
   input  logic [DATA_W-1:0]  in_cp0_data,
   input  logic [DATA_W-1:0]  in_hi,
   input  logic [DATA_W-1:0]  in_lo,
   input  logic [DATA_W-1:0]  in_link_pc,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_rdata_valid,
   output logic               wb_en,
   output logic [RADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               fwd_valid,
   output logic [RADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0]  fwd_data,
   output logic               misalign_err,
   output logic               load_timeout
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WAIT_MAX);

   wb_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Latched load context, captured when a load enters WAIT_LD.
   logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
   logic [1:0]         ld_size_q, ld_size_d;
   logic               ld_signed_q, ld_signed_d;
   logic [1:0]         ld_alow_q, ld_alow_d;
   logic               ld_we_q, ld_we_d;

   logic               wb_en_q, wb_en_d;
   logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]  wb_data_q, wb_data_d;
   logic               fwd_valid_q, fwd_valid_d;
   logic [RADDR_W-1:0] fwd_addr_q, fwd_addr_d;
   logic [DATA_W-1:0]  fwd_data_q, fwd_data_d;
   logic               mis_q, mis_d;
   logic               to_q, to_d;

   logic               accept;
   logic [DATA_W-1:0]  src_data;
   logic [1:0]         ext_size;
   logic               ext_signed;
   logic [1:0]         ext_alow;
   logic [DATA_W-1:0]  ext_data;
   logic               ext_mis;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      src_data = in_alu_result;
      case (in_wb_sel)
         WB_SEL_CP0:  src_data = in_cp0_data;
         WB_SEL_HI:   src_data = in_hi;
         WB_SEL_LO:   src_data = in_lo;
         WB_SEL_LINK: src_data = in_link_pc;
         default:     src_data = in_alu_result;
      endcase
   end

   // One extractor serves both uses: in IDLE it checks the incoming op's
   // alignment, in WAIT_LD it extracts using the latched context.
   assign ext_size   = (state_q == ST_IDLE) ? in_mem_size   : ld_size_q;
   assign ext_signed = (state_q == ST_IDLE) ? in_mem_signed : ld_signed_q;
   assign ext_alow   = (state_q == ST_IDLE) ? in_addr_low   : ld_alow_q;

   wb_stage_load_ext #(.DATA_W(DATA_W)) u_load_ext (
      .rdata_i      (mem_rdata),
      .size_i       (ext_size),
      .signed_i     (ext_signed),
      .addr_low_i   (ext_alow),
      .ext_o        (ext_data),
      .misaligned_o (ext_mis)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_rd_d     = ld_rd_q;
      ld_size_d   = ld_size_q;
      ld_signed_d = ld_signed_q;
      ld_alow_d   = ld_alow_q;
      ld_we_d     = ld_we_q;
      wb_en_d     = 1'b0;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      fwd_valid_d = wb_en_q;
      fwd_addr_d  = wb_addr_q;
      fwd_data_d  = wb_data_q;
      mis_d       = 1'b0;
      to_d        = 1'b0;

      if (flush) begin
         // Flush discards any in-flight load and beats mem_rdata_valid.
         state_d     = ST_IDLE;
         cnt_d       = '0;
         fwd_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (in_wb_sel == WB_SEL_MEM) begin
                     if (ext_mis) begin
                        mis_d = 1'b1;
                     end else begin
                        ld_rd_d     = in_rd;
                        ld_size_d   = in_mem_size;
                        ld_signed_d = in_mem_signed;
                        ld_alow_d   = in_addr_low;
                        ld_we_d     = in_reg_write;
                        cnt_d       = '0;
                        state_d     = ST_WAIT_LD;
                     end
                  end else begin
                     wb_en_d   = in_reg_write & (|in_rd);
                     wb_addr_d = in_rd;
                     wb_data_d = src_data;
                  end
               end
            end
            ST_WAIT_LD: begin
               if (mem_rdata_valid) begin
                  wb_en_d   = ld_we_q & (|ld_rd_q);
                  wb_addr_d = ld_rd_q;
                  wb_data_d = ext_data;
                  cnt_d     = '0;
                  state_d   = ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  to_d    = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wb_en_q     <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
         mis_q       <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wb_en_q     <= wb_en_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_addr_q  <= fwd_addr_d;
         fwd_data_q  <= fwd_data_d;
         mis_q       <= mis_d;
         to_q        <= to_d;
      end
   end

   // Load context is only meaningful while in WAIT_LD, so it needs no reset.
   always_ff @(posedge clock) begin
      ld_rd_q     <= ld_rd_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      ld_alow_q   <= ld_alow_d;
      ld_we_q     <= ld_we_d;
   end

   assign wb_en        = wb_en_q;
   assign wb_addr      = wb_addr_q;
   assign wb_data      = wb_data_q;
   assign fwd_valid    = fwd_valid_q;
   assign fwd_addr     = fwd_addr_q;
   assign fwd_data     = fwd_data_q;
   assign misalign_err = mis_q;
   assign load_timeout = to_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   localparam int DATA_W   = 32;
   localparam int RADDR_W  = 5;
   localparam int WAIT_MAX = 15;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic               reset, flush, in_valid, in_ready;
   logic [2:0]         in_wb_sel;
   logic               in_reg_write;
   logic [RADDR_W-1:0] in_rd;
   logic [1:0]         in_mem_size;
   logic               in_mem_signed;
   logic [1:0]         in_addr_low;
   logic [DATA_W-1:0]  in_alu_result, in_cp0_data, in_hi, in_lo, in_link_pc;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_rdata_valid;
   logic               wb_en, fwd_valid, misalign_err, load_timeout;
   logic [RADDR_W-1:0] wb_addr, fwd_addr;
   logic [DATA_W-1:0]  wb_data, fwd_data;

   wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wb_sel(in_wb_sel), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_mem_size(in_mem_size), .in_mem_signed(in_mem_signed),
      .in_addr_low(in_addr_low),
      .in_alu_result(in_alu_result), .in_cp0_data(in_cp0_data),
      .in_hi(in_hi), .in_lo(in_lo), .in_link_pc(in_link_pc),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .misalign_err(misalign_err), .load_timeout(load_timeout)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit                 armed = 1'b0;
   bit                 busy  = 1'b0;
   int                 waited = 0;
   logic [RADDR_W-1:0] c_rd;
   logic [1:0]         c_size, c_alow;
   bit                 c_sgn, c_we;
   bit                 e_ready = 1'b1, e_wb_en = 1'b0, e_fwd_valid = 1'b0;
   bit                 e_mis = 1'b0, e_to = 1'b0;
   logic [RADDR_W-1:0] e_wb_addr = '0, e_fwd_addr = '0;
   logic [DATA_W-1:0]  e_wb_data = '0, e_fwd_data = '0;

   function automatic bit m_misaligned(input int size, input int alow);
      if (size == 0) return 1'b0;
      if (size == 1) return (alow % 2) != 0;
      return alow != 0;
   endfunction

   function automatic logic [DATA_W-1:0] m_extract(input logic [DATA_W-1:0] rd,
                                                   input int size, input bit sgn,
                                                   input int alow);
      longint v;
      if (size == 0) begin
         v = longint'((rd >> (8 * alow)) & 32'hFF);
         if (sgn && v >= 128) v = v - 256;
      end else if (size == 1) begin
         v = longint'((rd >> (16 * (alow / 2))) & 32'hFFFF);
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         return rd;
      end
      return DATA_W'(v);
   endfunction

   function automatic logic [DATA_W-1:0] m_source(input int sel);
      case (sel)
         2: return in_cp0_data;
         3: return in_hi;
         4: return in_lo;
         5: return in_link_pc;
         default: return in_alu_result;
      endcase
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         armed = 1'b1; busy = 1'b0; waited = 0;
         e_wb_en = 0; e_wb_addr = '0; e_wb_data = '0;
         e_fwd_valid = 0; e_fwd_addr = '0; e_fwd_data = '0;
         e_mis = 0; e_to = 0; e_ready = 1;
      end else begin
         e_fwd_valid = flush ? 1'b0 : e_wb_en;
         e_fwd_addr  = e_wb_addr;
         e_fwd_data  = e_wb_data;
         e_wb_en = 0; e_mis = 0; e_to = 0;
         if (flush) begin
            busy = 1'b0;
         end else if (!busy) begin
            if (in_valid) begin
               if (in_wb_sel == 3'd1) begin
                  if (m_misaligned(int'(in_mem_size), int'(in_addr_low))) e_mis = 1;
                  else begin
                     busy = 1; waited = 0;
                     c_rd = in_rd; c_size = in_mem_size; c_sgn = in_mem_signed;
                     c_alow = in_addr_low; c_we = in_reg_write;
                  end
               end else begin
                  e_wb_en   = in_reg_write && (in_rd != 0);
                  e_wb_addr = in_rd;
                  e_wb_data = m_source(int'(in_wb_sel));
               end
            end
         end else if (mem_rdata_valid) begin
            e_wb_en   = c_we && (c_rd != 0);
            e_wb_addr = c_rd;
            e_wb_data = m_extract(mem_rdata, int'(c_size), c_sgn, int'(c_alow));
            busy = 0;
         end else begin
            waited++;
            if (waited >= WAIT_MAX) begin
               e_to = 1; busy = 0;
            end
         end
         e_ready = !busy;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (armed) begin
         chk("in_ready", 64'(in_ready), 64'(e_ready));
         chk("wb_en", 64'(wb_en), 64'(e_wb_en));
         chk("misalign_err", 64'(misalign_err), 64'(e_mis));
         chk("load_timeout", 64'(load_timeout), 64'(e_to));
         chk("fwd_valid", 64'(fwd_valid), 64'(e_fwd_valid));
         if (e_wb_en) begin
            chk("wb_addr", 64'(wb_addr), 64'(e_wb_addr));
            chk("wb_data", 64'(wb_data), 64'(e_wb_data));
         end
         if (e_fwd_valid) begin
            chk("fwd_addr", 64'(fwd_addr), 64'(e_fwd_addr));
            chk("fwd_data", 64'(fwd_data), 64'(e_fwd_data));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic [2:0] sel, input logic rw, input logic [RADDR_W-1:0] rd,
                        input logic [1:0] size, input logic sgn, input logic [1:0] alow);
      in_wb_sel = sel; in_reg_write = rw; in_rd = rd;
      in_mem_size = size; in_mem_signed = sgn; in_addr_low = alow;
      in_valid = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wb_en"}, 64'(wb_en), 64'd0);
      chk({tag, "_wb_addr"}, 64'(wb_addr), 64'd0);
      chk({tag, "_wb_data"}, 64'(wb_data), 64'd0);
      chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
      chk({tag, "_fwd_addr"}, 64'(fwd_addr), 64'd0);
      chk({tag, "_fwd_data"}, 64'(fwd_data), 64'd0);
      chk({tag, "_misalign"}, 64'(misalign_err), 64'd0);
      chk({tag, "_timeout"}, 64'(load_timeout), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
      $fatal(1);
   end

   initial begin
      int n_to;
      logic [2:0]        sels [6];
      logic [DATA_W-1:0] vals [6];
      reset = 1; flush = 0; in_valid = 0; in_wb_sel = 0; in_reg_write = 0; in_rd = 0;
      in_mem_size = 0; in_mem_signed = 0; in_addr_low = 0;
      in_alu_result = 0; in_cp0_data = 0; in_hi = 0; in_lo = 0; in_link_pc = 0;
      mem_rdata = 0; mem_rdata_valid = 0;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      reset = 0;
      @(negedge clock);

      // ALU write, then forwarding copy one cycle later
      in_alu_result = 32'h1234_5678;
      drive(3'd0, 1, 5'd8, 2'd0, 0, 2'd0);
      @(negedge clock);
      in_valid = 0;
      chk("alu_wb_en", 64'(wb_en), 64'd1);
      chk("alu_wb_addr", 64'(wb_addr), 64'd8);
      chk("alu_wb_data", 64'(wb_data), 64'h1234_5678);
      @(negedge clock);
      chk("alu_fwd_valid", 64'(fwd_valid), 64'd1);
      chk("alu_fwd_addr", 64'(fwd_addr), 64'd8);
      chk("alu_fwd_data", 64'(fwd_data), 64'h1234_5678);

      // lb signed, lane 3, data arrives two cycles after accept
      drive(3'd1, 1, 5'd9, 2'd0, 1, 2'd3);
      @(negedge clock);
      in_valid = 0;
      chk("lb_ready_wait1", 64'(in_ready), 64'd0);
      @(negedge clock);
      chk("lb_ready_wait2", 64'(in_ready), 64'd0);
      mem_rdata = 32'h80FF_0000; mem_rdata_valid = 1;
      @(negedge clock);
      mem_rdata_valid = 0;
      chk("lb_wb_en", 64'(wb_en), 64'd1);
      chk("lb_wb_data", 64'(wb_data), 64'hFFFF_FF80);
      chk("lb_ready_after", 64'(in_ready), 64'd1);

      // lhu lane 1
      drive(3'd1, 1, 5'd10, 2'd1, 0, 2'd2);
      @(negedge clock);
      in_valid = 0;
      mem_rdata = 32'hBEEF_1234; mem_rdata_valid = 1;
      @(negedge clock);
      mem_rdata_valid = 0;
      chk("lhu_wb_data", 64'(wb_data), 64'h0000_BEEF);

      // lh signed lane 0
      drive(3'd1, 1, 5'd11, 2'd1, 1, 2'd0);
      @(negedge clock);
      in_valid = 0;
      mem_rdata = 32'h1234_8765; mem_rdata_valid = 1;
      @(negedge clock);
      mem_rdata_valid = 0;
      chk("lh_wb_data", 64'(wb_data), 64'hFFFF_8765);

      // misaligned half
      drive(3'd1, 1, 5'd12, 2'd1, 1, 2'd1);
      @(negedge clock);
      in_valid = 0;
      chk("mis_pulse", 64'(misalign_err), 64'd1);
      chk("mis_wb_en", 64'(wb_en), 64'd0);
      chk("mis_ready", 64'(in_ready), 64'd1);
      @(negedge clock);
      chk("mis_pulse_end", 64'(misalign_err), 64'd0);

      // misaligned word (size 3 aliases word)
      drive(3'd1, 1, 5'd12, 2'd3, 0, 2'd2);
      @(negedge clock);
      in_valid = 0;
      chk("misw_pulse", 64'(misalign_err), 64'd1);

      // timeout: valid never comes
      drive(3'd1, 1, 5'd13, 2'd2, 0, 2'd0);
      @(negedge clock);
      in_valid = 0;
      n_to = 0;
      for (int i = 0; i < 25; i++) begin
         if (load_timeout) n_to++;
         @(negedge clock);
      end
      chk("timeout_count", 64'(n_to), 64'd1);
      chk("timeout_ready", 64'(in_ready), 64'd1);

      // flush in WAIT_LD with data valid the same cycle
      drive(3'd1, 1, 5'd14, 2'd2, 0, 2'd0);
      @(negedge clock);
      in_valid = 0;
      flush = 1; mem_rdata = 32'hCAFE_F00D; mem_rdata_valid = 1;
      @(negedge clock);
      flush = 0; mem_rdata_valid = 0;
      chk("flush_wb_en", 64'(wb_en), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);

      // $zero is never written
      in_alu_result = 32'hDEAD_BEEF;
      drive(3'd0, 1, 5'd0, 2'd0, 0, 2'd0);
      @(negedge clock);
      in_valid = 0;
      chk("rd0_wb_en", 64'(wb_en), 64'd0);

      // reset in the middle of a load
      drive(3'd1, 1, 5'd15, 2'd2, 0, 2'd0);
      @(negedge clock);
      in_valid = 0;
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      chk_all_zero("midreset");
      reset = 0;
      @(negedge clock);

      // back-to-back non-MEM ops, one per cycle
      in_alu_result = 32'hA1A1_0001; in_cp0_data = 32'hC0C0_0002;
      in_hi = 32'h4141_0003; in_lo = 32'h1010_0004; in_link_pc = 32'h1C1C_0005;
      sels = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      vals = '{32'hA1A1_0001, 32'hC0C0_0002, 32'h4141_0003,
               32'h1010_0004, 32'h1C1C_0005, 32'hA1A1_0001};
      for (int i = 0; i < 6; i++) begin
         drive(sels[i], 1, RADDR_W'(16 + i), 2'd0, 0, 2'd0);
         @(negedge clock);
         chk("b2b_wb_en", 64'(wb_en), 64'd1);
         chk("b2b_wb_addr", 64'(wb_addr), 64'(16 + i));
         chk("b2b_wb_data", 64'(wb_data), 64'(vals[i]));
      end
      in_valid = 0;
      repeat (3) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
